// File: rtl/systolic_feeder.sv
// systolic_feeder: stages operands for systolic_array.
// On start, reads the N x K weight matrix and the N x M im2col matrix through a
// one-cycle-latency memory read port into internal buffers, then streams one
// reduction row per cycle on X/W with a valid qualifier and a final done pulse.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - one-cycle request, sampled only when idle
//   addr_rd  - registered memory read address
//   data_rd  - memory read data, valid one cycle after addr_rd
//   X        - im2col row, word j at bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
//   W        - weight row, same packing as X
//   valid    - X/W carry a live row
//   busy     - high from leaving idle until done
//   done     - one-cycle completion pulse
module systolic_feeder #(
    parameter int unsigned M                       = 9,
    parameter int unsigned N                       = 27,
    parameter int unsigned K                       = 5,
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned ADDR_WIDTH              = 32,
    parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE   = 32'h0000_1000,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE   = 32'h0000_2000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   addr_rd,
    input  logic [DATA_WIDTH-1:0]   data_rd,
    output logic [DATA_WIDTH*M-1:0] X,
    output logic [DATA_WIDTH*K-1:0] W,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned R    = N * (K + M);
    localparam int unsigned NK   = N * K;
    localparam int unsigned RC_W = $clog2(R + 1);
    localparam int unsigned SC_W = $clog2(N + 1);
    localparam int unsigned NI_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KI_W = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned MI_W = (M > 1) ? $clog2(M) : 1;

    localparam logic [RC_W-1:0] RC_R    = RC_W'(R);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(R - 1);
    localparam logic [RC_W-1:0] RC_NK   = RC_W'(NK);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(N - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStream, StFin} state_e;

    state_e                  state_q;
    logic [RC_W-1:0]         rc_q;
    logic [SC_W-1:0]         sc_q;
    logic                    cap_vld_q;
    logic [RC_W-1:0]         cap_idx_q;
    logic [DATA_WIDTH*K-1:0] w_last_q;

    // Operand buffers; not reset, every slot is rewritten by each load.
    logic [DATA_WIDTH-1:0] wbuf [N][K];
    logic [DATA_WIDTH-1:0] xbuf [N][M];

    logic [RC_W-1:0]       rc_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  cap_is_w;
    logic [RC_W-1:0]       cap_off;
    logic [NI_W-1:0]       cap_row;
    logic [KI_W-1:0]       cap_col_w;
    logic [MI_W-1:0]       cap_col_x;
    logic [NI_W-1:0]       sc_idx;

    // Address of the read following the one currently presented.
    always_comb begin
        rc_next = rc_q + 1'b1;
        if (rc_next < RC_NK) begin
            addr_next = WEIGHT_BASE + ADDR_WIDTH'(rc_next);
        end else begin
            addr_next = IM2COL_BASE + ADDR_WIDTH'(rc_next - RC_NK);
        end
    end

    // cap_idx_q is the read index whose data is on data_rd this cycle.
    always_comb begin
        cap_is_w  = cap_idx_q < RC_NK;
        cap_off   = cap_is_w ? cap_idx_q : cap_idx_q - RC_NK;
        cap_row   = cap_is_w ? NI_W'(cap_off / RC_W'(K)) : NI_W'(cap_off / RC_W'(M));
        cap_col_w = KI_W'(cap_off % RC_W'(K));
        cap_col_x = MI_W'(cap_off % RC_W'(M));
    end

    always_ff @(posedge clk) begin
        if (state_q == StLoad && cap_vld_q) begin
            if (cap_is_w) begin
                wbuf[cap_row][cap_col_w] <= data_rd;
            end else begin
                xbuf[cap_row][cap_col_x] <= data_rd;
            end
        end
    end

    // Rows are muxed straight out of the buffers so the final captured word can be
    // streamed on the very next cycle; W otherwise shows the last streamed row.
    always_comb begin
        sc_idx = NI_W'(sc_q);
        X      = '0;
        W      = w_last_q;
        if (state_q == StStream) begin
            for (int j = 0; j < M; j++) begin
                X[j*DATA_WIDTH +: DATA_WIDTH] = xbuf[sc_idx][j];
            end
            for (int j = 0; j < K; j++) begin
                W[j*DATA_WIDTH +: DATA_WIDTH] = wbuf[sc_idx][j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rc_q      <= '0;
            sc_q      <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            w_last_q  <= '0;
            addr_rd   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StLoad;
                        rc_q      <= '0;
                        cap_vld_q <= 1'b0;
                        addr_rd   <= WEIGHT_BASE;
                        busy      <= 1'b1;
                    end
                end
                StLoad: begin
                    cap_vld_q <= rc_q < RC_R;
                    cap_idx_q <= rc_q;
                    if (rc_q < RC_R) begin
                        rc_q <= rc_next;
                        if (rc_next < RC_R) begin
                            addr_rd <= addr_next;
                        end
                    end
                    if (cap_vld_q && cap_idx_q == RC_LAST) begin
                        state_q   <= StStream;
                        cap_vld_q <= 1'b0;
                        sc_q      <= '0;
                        valid     <= 1'b1;
                    end
                end
                StStream: begin
                    w_last_q <= W;
                    sc_q     <= sc_q + 1'b1;
                    if (sc_q == SC_LAST) begin
                        state_q <= StFin;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: default load/stream, address trace, ignored
// start pulses, back-to-back operation, reset in LOAD and STREAM, and a 1x1x1 instance.
module tb_systolic_feeder;

    localparam int unsigned M  = 9;
    localparam int unsigned N  = 27;
    localparam int unsigned K  = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned R  = N * (K + M);
    localparam logic [31:0] WB = 32'h0000_1000;
    localparam logic [31:0] IB = 32'h0000_2000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   addr_rd;
    logic [DW-1:0]   data_rd;
    logic [DW*M-1:0] x;
    logic [DW*K-1:0] w;
    logic            valid;
    logic            busy;
    logic            done;

    logic            start_s;
    logic [AW-1:0]   addr_rd_s;
    logic [DW-1:0]   data_rd_s;
    logic [DW-1:0]   x_s;
    logic [DW-1:0]   w_s;
    logic            valid_s;
    logic            busy_s;
    logic            done_s;

    logic [31:0]     salt;
    logic [DW*K-1:0] w_prev;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    systolic_feeder #(
        .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .WEIGHT_BASE(WB), .IM2COL_BASE(IB)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .addr_rd(addr_rd), .data_rd(data_rd),
        .X(x), .W(w), .valid(valid), .busy(busy), .done(done)
    );

    systolic_feeder #(
        .M(1), .N(1), .K(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .WEIGHT_BASE(WB), .IM2COL_BASE(IB)
    ) u_dut_small (
        .clk(clk), .rst(rst), .start(start_s), .addr_rd(addr_rd_s), .data_rd(data_rd_s),
        .X(x_s), .W(w_s), .valid(valid_s), .busy(busy_s), .done(done_s)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= WB && a < WB + N * K) return (32'h1000_0000 + (a - WB)) ^ salt;
        if (a >= IB && a < IB + N * M) return (32'h2000_0000 + (a - IB)) ^ salt;
        return 32'hdead_beef;
    endfunction

    // Shared word memory with one cycle of read latency.
    always @(posedge clk) begin
        data_rd   <= mem_word(addr_rd);
        data_rd_s <= mem_word(addr_rd_s);
    end

    function automatic logic [31:0] exp_addr(input int r);
        if (r < N * K) return WB + r;
        return IB + (r - N * K);
    endfunction

    function automatic logic [DW*M-1:0] exp_x(input int i);
        logic [DW*M-1:0] v;
        for (int j = 0; j < M; j++) v[j*DW +: DW] = (32'h2000_0000 + i * M + j) ^ salt;
        return v;
    endfunction

    function automatic logic [DW*K-1:0] exp_w(input int i);
        logic [DW*K-1:0] v;
        for (int j = 0; j < K; j++) v[j*DW +: DW] = (32'h1000_0000 + i * K + j) ^ salt;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, " addr_rd"}, addr_rd, 0);
        check_eq({tag, " X"}, x, 0);
        check_eq({tag, " W"}, w, 0);
        check_eq({tag, " valid"}, valid, 0);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " done"}, done, 0);
        check_eq({tag, " small W"}, w_s, 0);
    endtask

    // Asserts reset mid-operation, changes memory contents under it, releases.
    task automatic apply_reset(input string tag);
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero(tag);
        salt = salt ^ 32'h5a5a_0000;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        w_prev = '0;
    endtask

    // Caller is at a negedge; start is sampled at the next edge (cycle 0).
    task automatic run_op(input int abort_at);
        int beat;
        logic exp_valid;
        start = 1'b1;
        for (int t = 1; t <= R + N + 3; t++) begin
            @(negedge clk);
            start = (t == 10 || t == 390);
            if (t == abort_at) begin
                apply_reset($sformatf("rst@%0d", t));
                return;
            end
            if (t <= R) check_eq($sformatf("addr t=%0d", t), addr_rd, exp_addr(t - 1));
            exp_valid = (t >= R + 2 && t <= R + N + 1);
            check_eq($sformatf("busy t=%0d", t), busy, (t <= R + N + 1));
            check_eq($sformatf("valid t=%0d", t), valid, exp_valid);
            check_eq($sformatf("done t=%0d", t), done, (t == R + N + 2));
            beat = t - (R + 2);
            if (exp_valid) begin
                check_eq($sformatf("X beat=%0d", beat), x, exp_x(beat));
                check_eq($sformatf("W beat=%0d", beat), w, exp_w(beat));
            end else begin
                check_eq($sformatf("X idle t=%0d", t), x, 0);
                check_eq($sformatf("W hold t=%0d", t), w, (t > R + N + 1) ? exp_w(N - 1) : w_prev);
            end
        end
        w_prev = exp_w(N - 1);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        start_s = 1'b0;
        salt    = 32'h0;
        w_prev  = '0;
        #2;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(0);      // default run with ignored starts at 10 and 390
        run_op(0);      // restart at cycle 408 of the previous run
        run_op(200);    // reset during LOAD
        run_op(0);
        run_op(395);    // reset during STREAM
        run_op(0);
        start = 1'b0;

        // 1x1x1 instance: R=2, beat at cycle 4, done at 5.
        @(negedge clk);
        start_s = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (t == 1) check_eq("small addr t=1", addr_rd_s, WB);
            if (t == 2) check_eq("small addr t=2", addr_rd_s, IB);
            check_eq($sformatf("small busy t=%0d", t), busy_s, (t <= 4));
            check_eq($sformatf("small valid t=%0d", t), valid_s, (t == 4));
            check_eq($sformatf("small done t=%0d", t), done_s, (t == 5));
            check_eq($sformatf("small X t=%0d", t), x_s, (t == 4) ? (32'h2000_0000 ^ salt) : 32'h0);
            check_eq($sformatf("small W t=%0d", t), w_s, (t >= 4) ? (32'h1000_0000 ^ salt) : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
